// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit owning HI/LO; 2-cycle multiply, 32-step restoring divide.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  input  logic        mdu_flush_i,
  output logic [31:0] mdu_result_o,
  output logic        mdu_stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, DIV = 3'd2, FIX = 3'd3, DONE = 3'd4;
  localparam logic [3:0] OP_DIV = 4'd1, OP_DIVU = 4'd2, OP_MUL = 4'd3, OP_MULT = 4'd4, OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI = 4'd6, OP_MFLO = 4'd7, OP_MTHI = 4'd8, OP_MTLO = 4'd9;
  logic [2:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, res_q, res_d, a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic        arith, sgn, neg_a, neg_b;
  logic [31:0] dvs;
  logic [32:0] shl, diff;
  logic [63:0] prod;
  always_comb begin
    arith = mdu_op_i >= OP_DIV && mdu_op_i <= OP_MULTU;
    sgn = op_q == OP_DIV || op_q == OP_MUL || op_q == OP_MULT;
    neg_a = sgn & a_q[31];
    neg_b = sgn & b_q[31];
    prod = {{32{neg_a}}, a_q} * {{32{neg_b}}, b_q};
    dvs = neg_b ? -b_q : b_q;
    // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
    shl = {rem_q, quo_q[31]};
    diff = shl - {1'b0, dvs};
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    res_d = res_q;
    a_d = a_q;
    b_d = b_q;
    quo_d = quo_q;
    rem_d = rem_q;
    if (mdu_flush_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (arith) begin
        state_d = mdu_op_i >= OP_MUL ? MUL : DIV;
        op_d = mdu_op_i;
        a_d = mdu_a_i;
        b_d = mdu_b_i;
        cnt_d = '0;
        rem_d = '0;
        quo_d = mdu_op_i == OP_DIV && mdu_a_i[31] ? -mdu_a_i : mdu_a_i;
      end else begin
        hi_d = mdu_op_i == OP_MTHI ? mdu_a_i : hi_q;
        lo_d = mdu_op_i == OP_MTLO ? mdu_a_i : lo_q;
      end
      MUL: begin
        state_d = DONE;
        if (op_q == OP_MUL) res_d = prod[31:0];
        else {hi_d, lo_d} = prod;
      end
      DIV: begin
        rem_d = diff[32] ? shl[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 5'd1;
        state_d = cnt_q == 5'd31 ? FIX : DIV;
      end
      FIX: begin
        state_d = DONE;
        lo_d = b_q == '0 ? '1 : (neg_a ^ neg_b) ? -quo_q : quo_q;
        hi_d = b_q == '0 ? a_q : neg_a ? -rem_q : rem_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      res_q <= res_d;
      a_q <= a_d;
      b_q <= b_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end
  assign mdu_stall_o = !mdu_flush_i && ((state_q == IDLE && arith) || state_q == MUL || state_q == DIV || state_q == FIX);
  assign mdu_result_o = state_q == IDLE ? (mdu_op_i == OP_MFHI ? hi_q : mdu_op_i == OP_MFLO ? lo_q : '0)
                      : (state_q == DONE && op_q == OP_MUL) ? res_q : '0;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu; a transaction-level HI/LO model is checked every cycle.
module tb_mdu;
  logic        clk = 0, rst = 1, mdu_flush_i = 0;
  logic [3:0]  mdu_op_i = 0;
  logic [31:0] mdu_a_i = 0, mdu_b_i = 0;
  logic [31:0] mdu_result_o, hi_o, lo_o;
  logic        mdu_stall_o;
  int n_cmp = 0, n_bad = 0;

  mdu dut (.clk(clk), .rst(rst), .mdu_op_i(mdu_op_i), .mdu_a_i(mdu_a_i), .mdu_b_i(mdu_b_i),
           .mdu_flush_i(mdu_flush_i), .mdu_result_o(mdu_result_o), .mdu_stall_o(mdu_stall_o),
           .hi_o(hi_o), .lo_o(lo_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an issued op computes its answer arithmetically and occupies m_busy stall cycles
  logic [31:0] m_hi, m_lo, m_res, p_hi, p_lo;
  logic        p_wr, m_done, e_stall;
  logic [31:0] e_res;
  int          m_busy;

  task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    int unsigned ua, ub;
    longint sp;
    longint unsigned up;
    sa = a; sb = b; ua = a; ub = b;
    p_wr = 1; m_res = 0;
    if (op == 1 || op == 2) begin
      m_busy = 33;
      if (b == 0) begin p_lo = 32'hFFFFFFFF; p_hi = a; end
      else if (op == 1 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin p_lo = 32'h80000000; p_hi = 0; end
      else if (op == 1) begin p_lo = sa / sb; p_hi = sa % sb; end
      else begin p_lo = ua / ub; p_hi = ua % ub; end
    end else begin
      m_busy = 1;
      sp = longint'(sa) * longint'(sb);
      up = longint'(ua) * longint'(ub);
      if (op == 5) {p_hi, p_lo} = up;
      else {p_hi, p_lo} = sp;
      if (op == 3) begin m_res = p_lo; p_wr = 0; end
    end
  endtask

  initial begin
    m_hi = 0; m_lo = 0; m_res = 0; m_busy = 0; m_done = 0; p_wr = 0; p_hi = 0; p_lo = 0;
    forever begin
      @(negedge clk);
      if (rst) begin m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_res = 0; end
      if (m_busy > 0) begin e_stall = !mdu_flush_i; e_res = 0; end
      else if (m_done) begin e_stall = 0; e_res = m_res; end
      else begin
        e_stall = mdu_op_i >= 1 && mdu_op_i <= 5 && !mdu_flush_i;
        e_res = mdu_op_i == 6 ? m_hi : mdu_op_i == 7 ? m_lo : 0;
      end
      chk("stall", {31'b0, mdu_stall_o}, {31'b0, e_stall});
      chk("result", mdu_result_o, e_res);
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      if (!rst) begin
        if (m_busy > 0) begin
          if (mdu_flush_i) m_busy = 0;
          else begin
            m_busy--;
            if (m_busy == 0) begin
              m_done = 1;
              if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            end
          end
        end else if (m_done) m_done = 0;
        else if (!mdu_flush_i) begin
          if (mdu_op_i >= 1 && mdu_op_i <= 5) model_issue(mdu_op_i, mdu_a_i, mdu_b_i);
          else if (mdu_op_i == 8) m_hi = mdu_a_i;
          else if (mdu_op_i == 9) m_lo = mdu_a_i;
        end
      end
    end
  end

  task automatic op_cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    mdu_op_i = op; mdu_a_i = a; mdu_b_i = b;
  endtask

  // Issue and hold the op until the stall drops; returns at the DONE-cycle negedge
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
    op_cycle(op, a, b);
    cyc = 0;
    @(negedge clk);
    while (mdu_stall_o && cyc < 100) begin cyc++; @(negedge clk); end
  endtask

  initial begin
    int c;
    @(negedge clk);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_res", mdu_result_o, 0);
    @(posedge clk); #1 rst = 0;
    run(4, 32'hFFFFFFFE, 3, c);
    chk("mult_lat", c, 2); chk("mult_hi", hi_o, 32'hFFFFFFFF); chk("mult_lo", lo_o, 32'hFFFFFFFA);
    run(5, 32'hFFFFFFFE, 3, c);
    chk("multu_hi", hi_o, 32'h2); chk("multu_lo", lo_o, 32'hFFFFFFFA);
    run(1, 32'hFFFFFFF9, 2, c);
    chk("div_lat", c, 34); chk("div_lo", lo_o, 32'hFFFFFFFD); chk("div_hi", hi_o, 32'hFFFFFFFF);
    run(2, 100, 7, c);
    chk("divu_lo", lo_o, 14); chk("divu_hi", hi_o, 2);
    run(1, 7, 32'hFFFFFFFE, c);
    chk("div_nb_lo", lo_o, 32'hFFFFFFFD); chk("div_nb_hi", hi_o, 1);
    run(2, 5, 0, c);
    chk("divu0_lat", c, 34); chk("divu0_lo", lo_o, 32'hFFFFFFFF); chk("divu0_hi", hi_o, 5);
    run(1, 32'hFFFFFFFB, 0, c);
    chk("div0_lo", lo_o, 32'hFFFFFFFF); chk("div0_hi", hi_o, 32'hFFFFFFFB);
    run(1, 32'h80000000, 32'hFFFFFFFF, c);
    chk("ovf_lo", lo_o, 32'h80000000); chk("ovf_hi", hi_o, 0);
    run(3, 6, 7, c);
    chk("mul_res", mdu_result_o, 42); chk("mul_hi", hi_o, 0); chk("mul_lo", lo_o, 32'h80000000);
    op_cycle(8, 32'h1234, 0);
    op_cycle(6, 0, 0);
    @(negedge clk);
    chk("mfhi_res", mdu_result_o, 32'h1234); chk("mfhi_stall", {31'b0, mdu_stall_o}, 0);
    op_cycle(8, 32'hAAAA5555, 0);
    op_cycle(9, 32'h0F0F0F0F, 0);
    op_cycle(1, 100, 3);
    repeat (11) @(posedge clk);
    #1 mdu_flush_i = 1;
    @(negedge clk);
    chk("flush_stall", {31'b0, mdu_stall_o}, 0);
    chk("flush_hi", hi_o, 32'hAAAA5555); chk("flush_lo", lo_o, 32'h0F0F0F0F);
    @(posedge clk); #1 mdu_flush_i = 0; mdu_op_i = 7;
    @(negedge clk);
    chk("flush_mflo", mdu_result_o, 32'h0F0F0F0F);
    op_cycle(5, 5, 5);
    @(posedge clk); #1 rst = 1; mdu_op_i = 0;
    @(negedge clk);
    chk("mrst_hi", hi_o, 0); chk("mrst_lo", lo_o, 0);
    chk("mrst_stall", {31'b0, mdu_stall_o}, 0); chk("mrst_res", mdu_result_o, 0);
    @(posedge clk); #1 rst = 0;
    run(4, 2, 3, c);
    chk("post_lat", c, 2); chk("post_lo", lo_o, 6); chk("post_hi", hi_o, 0);
    op_cycle(0, 0, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage of the SimMIPS core. Consumes the 4-bit MDU opcode produced by instruction decode, together with the rs/rt operand values, and owns the architectural HI/LO registers. Multiplies take two cycles and divides run on a 32-iteration radix-2 restoring divider. While an operation is in flight, the unit stalls the pipeline and returns MUL/MFHI/MFLO results to the EX result mux.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- mdu_op_i  in  4  0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO, 10–15 treated as 0
- mdu_a_i  in  32  rs value (dividend / multiplicand / MTHI-MTLO source)
- mdu_b_i  in  32  rt value (divisor / multiplier)
- mdu_flush_i  in  1  EX flush (exception/interrupt); aborts any in-flight operation
- mdu_result_o  out  32  value for the rd write: HI for MFHI, LO for MFLO, low product for MUL, else 0
- mdu_stall_o  out  1  holds IF/ID/EX while high
- hi_o, lo_o  out  32  current HI/LO (debug/trace)

## Operation
- Arithmetic ops are 1–5. FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE behaviour by op:
  - Arithmetic op and no flush: latch operands and op, then go to MUL (ops 3/4/5) or DIV (ops 1/2). mdu_stall_o=1 combinationally in this cycle.
  - MTHI/MTLO: write HI/LO from mdu_a_i at the edge. No stall.
  - MFHI/MFLO: drive the current HI/LO combinationally. No stall.
- MUL state (1 cycle):
  - Compute the 64-bit product: signed for MULT/MUL, unsigned for MULTU.
  - MULT/MULTU: {HI,LO} <= product.
  - MUL: HI/LO unchanged; product[31:0] is held in a result register.
  - Next state DONE.
- DIV state (32 cycles, 5-bit counter 0..31):
  - DIV operates on magnitudes |a|,|b|; DIVU operates on raw values.
  - One quotient bit per cycle using a 33-bit partial remainder.
  - At count 31, go to FIX.
- FIX state (1 cycle):
  - DIV sign rule: quotient is negated if the operand signs differ; remainder takes the sign of the dividend. Results are truncated to 32 bits.
  - LO <= quotient, HI <= remainder. Next state DONE.
- Divide by zero (DIV or DIVU): full latency. LO=32'hFFFFFFFF, HI=a. No sign fix-up.
- DIV overflow (0x80000000 / 0xFFFFFFFF): LO=32'h80000000, HI=0.
- DONE state (1 cycle):
  - mdu_stall_o=0. The completed instruction (still present on mdu_op_i) is ignored and not relaunched.
  - mdu_result_o = held MUL product when the completed op is MUL, else 0.
  - Next state IDLE.
- Flush:
  - mdu_flush_i in MUL/DIV/FIX: go to IDLE, HI/LO unchanged, stall drops in the same cycle.
  - Flush in IDLE suppresses launch and MTHI/MTLO writes.
  - Flush in DONE: go to IDLE (HI/LO already committed).
- mdu_stall_o = (IDLE and arithmetic op and !flush) or state ∈ {MUL, DIV, FIX}, with flush forcing 0.

## Timing
- Reset (asynchronous, active-high): state=IDLE, HI=LO=0, counter=0, result register=0. Outputs: mdu_stall_o=0, mdu_result_o=0, hi_o=lo_o=0.
- MULT/MULTU/MUL:
  - Stall high 2 cycles (issue, MUL).
  - DONE on the 3rd cycle. HI/LO visible from the DONE cycle.
- DIV/DIVU:
  - Stall high 34 cycles (issue + 32 DIV + FIX).
  - DONE on cycle 35. HI/LO visible in DONE.
- MTHI/MTLO followed immediately by MFHI/MFLO: the new value is visible the next cycle (no bypass needed).
- Reset asserted mid-operation: immediate return to reset values, in-flight result discarded.
- Back-to-back arithmetic ops: the second is launched in the IDLE cycle after DONE.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> stall 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat with MULTU -> HI=0x2, LO=0xFFFFFFFA.
- DIV a=-7 (0xFFFFFFF9), b=2 -> stall exactly 34 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MUL 6×7 -> mdu_result_o=42 in the DONE cycle, HI/LO unchanged. MTHI 0x1234 then MFHI next cycle -> mdu_result_o=0x1234 with no stall.
- Assert mdu_flush_i at DIV iteration 10 -> stall drops the same cycle, HI/LO keep their prior values, a new MFLO in the next cycle returns the old LO.
- Pulse rst during the MUL state -> all outputs 0 immediately. A following MULT 2×3 completes normally with LO=6.
